pickup_spawner: RTL and testbench

Consumes the 10-bit pseudo-random stream from the game's LFSR generator and turns it into pickup items on the playfield. Waits a fixed number of frames, draws a random in-bounds position and a pickup type, then asks the obstacle map whether that spot is free. Keeps the pickup alive until a tank collects it or it expires. Sits between the random generator and the game-state/sprite logic.

---
 rtl/pickup_spawner_pkg.sv | 28 ++
 rtl/pickup_spawner_if.sv | 35 +++
 rtl/pickup_spawner_frame_counter.sv | 26 ++
 rtl/pickup_spawner.sv | 217 +++++++++++++++++++++
 tb/tb_pickup_spawner.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/pickup_spawner_pkg.sv
// Shared game package: playfield size, spawner FSM states, pickup kinds
// and a small elaboration-time helper.
package pickup_spawner_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [2:0] {
    IDLE,
    COOLDOWN,
    DRAW_X,
    DRAW_Y,
    CHECK,
    ACTIVE
  } spawn_state_t;

  typedef enum logic [1:0] {
    HEALTH = 2'd0,
    AMMO   = 2'd1,
    SPEED  = 2'd2,
    SHIELD = 2'd3
  } pickup_type_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pickup_spawner_if.sv
// Signal bundle between the pickup spawner and its neighbours
// (LFSR, obstacle map, game-state / sprite logic).
//   slave  : the spawner side (drives candidate and pickup outputs)
//   master : the game side (drives ticks, random stream, map answer)
interface pickup_spawner_if;
  import pickup_spawner_pkg::*;

  logic         frame_tick;
  logic         game_active;
  logic [9:0]   rand_in;
  logic         collected;
  logic         blocked;

  logic         cand_valid;
  logic [9:0]   cand_x;
  logic [9:0]   cand_y;
  logic         pickup_active;
  logic [9:0]   pickup_x;
  logic [9:0]   pickup_y;
  pickup_type_t pickup_type;
  logic         spawn_pulse;
  logic         expire_pulse;

  modport slave (
    input  frame_tick, game_active, rand_in, collected, blocked,
    output cand_valid, cand_x, cand_y, pickup_active, pickup_x, pickup_y,
           pickup_type, spawn_pulse, expire_pulse
  );

  modport master (
    output frame_tick, game_active, rand_in, collected, blocked,
    input  cand_valid, cand_x, cand_y, pickup_active, pickup_x, pickup_y,
           pickup_type, spawn_pulse, expire_pulse
  );
endinterface

// File: rtl/pickup_spawner_frame_counter.sv
// Clearable frame counter with terminal-count compare.
//   Clk, Reset_n : clock, async active-low reset
//   clr          : synchronous clear (wins over en)
//   en           : count this cycle (a qualified frame_tick)
//   tc_val       : terminal count to compare against
//   tc           : en is high and the count sits at tc_val
module pickup_spawner_frame_counter #(
  parameter int W = 10
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] tc_val,
  output logic         tc
);
  logic [W-1:0] cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)  cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= cnt + 1'b1;
  end

  assign tc = en && (cnt == tc_val);
endmodule

// File: rtl/pickup_spawner.sv
// Pickup spawner: waits SPAWN_DELAY frames, draws an in-bounds position
// and a type from the LFSR stream, asks the obstacle map whether the
// spot is free and keeps the pickup alive until collected (or expired).
//   Clk, Reset_n : clock, async active-low reset
//   bus          : pickup_spawner_if.slave (ticks, random stream, map
//                  handshake, pickup outputs); all outputs registered
// Optional feature: define PICKUP_LIFETIME_EN to expire pickups after
// LIFETIME frames and raise expire_pulse; otherwise expire_pulse is 0.
module pickup_spawner #(
  parameter int SCREEN_W    = pickup_spawner_pkg::SCREEN_W,
  parameter int SCREEN_H    = pickup_spawner_pkg::SCREEN_H,
  parameter int PICKUP_SIZE = 16,
  parameter int SPAWN_DELAY = 300,
  parameter int LIFETIME    = 600,
  parameter int MAX_TRIES   = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  pickup_spawner_if.slave  bus
);
  import pickup_spawner_pkg::*;

  localparam int CNT_MAX = max2(SPAWN_DELAY, LIFETIME);
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int TRY_W   = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;

  localparam logic [9:0]       X_LIM    = 10'(SCREEN_W - PICKUP_SIZE);
  localparam logic [8:0]       Y_LIM    = 9'(SCREEN_H - PICKUP_SIZE);
  localparam logic [CNT_W-1:0] SPAWN_TC = CNT_W'(SPAWN_DELAY - 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

  spawn_state_t state, state_n;

  logic [TRY_W-1:0] tries_q, tries_n;
  logic [9:0]       cand_x_q, cand_x_n, cand_y_q, cand_y_n;
  pickup_type_t     cand_type_q, cand_type_n;
  logic             cand_valid_q, cand_valid_n;
  logic             active_q, active_n;
  logic [9:0]       px_q, px_n, py_q, py_n;
  pickup_type_t     ptype_q, ptype_n;
  logic             spawn_q, spawn_n;
  logic             expire_q, expire_n;
  logic             try_fail;

  logic             cnt_clr, cnt_en, cnt_tc;
  logic [CNT_W-1:0] cnt_tc_val;

  // One counter serves both the spawn delay and the lifetime; it is
  // cleared on every state change so it never needs to wrap.
`ifdef PICKUP_LIFETIME_EN
  localparam logic [CNT_W-1:0] LIFE_TC = CNT_W'(LIFETIME - 1);
  assign cnt_en     = bus.frame_tick && (state == COOLDOWN || state == ACTIVE);
  assign cnt_tc_val = (state == ACTIVE) ? LIFE_TC : SPAWN_TC;
`else
  assign cnt_en     = bus.frame_tick && (state == COOLDOWN);
  assign cnt_tc_val = SPAWN_TC;
`endif

  pickup_spawner_frame_counter #(.W(CNT_W)) u_frame_cnt (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .tc_val (cnt_tc_val),
    .tc     (cnt_tc)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n      = state;
    tries_n      = tries_q;
    cand_x_n     = cand_x_q;
    cand_y_n     = cand_y_q;
    cand_type_n  = cand_type_q;
    cand_valid_n = 1'b0;
    active_n     = active_q;
    px_n         = px_q;
    py_n         = py_q;
    ptype_n      = ptype_q;
    spawn_n      = 1'b0;
    expire_n     = 1'b0;
    try_fail     = 1'b0;

    case (state)
      IDLE: if (bus.game_active) state_n = COOLDOWN;

      COOLDOWN: begin
        tries_n = '0;
        if (cnt_tc) state_n = DRAW_X;
      end

      DRAW_X: begin
        if (bus.rand_in < X_LIM) begin
          cand_x_n = bus.rand_in;
          state_n  = DRAW_Y;
        end else begin
          try_fail = 1'b1;
        end
      end

      // Type comes from the top two bits of the same draw as y.
      DRAW_Y: begin
        if (bus.rand_in[8:0] < Y_LIM) begin
          cand_y_n     = {1'b0, bus.rand_in[8:0]};
          cand_type_n  = pickup_type_t'(bus.rand_in[9:8]);
          cand_valid_n = 1'b1;
          state_n      = CHECK;
        end else begin
          try_fail = 1'b1;
        end
      end

      // The map answers while cand_valid is high (the cycle after the
      // accepted y draw).
      CHECK: begin
        if (!bus.blocked) begin
          px_n     = cand_x_q;
          py_n     = cand_y_q;
          ptype_n  = cand_type_q;
          active_n = 1'b1;
          spawn_n  = 1'b1;
          state_n  = ACTIVE;
        end else begin
          try_fail = 1'b1;
        end
      end

      // Collection wins over a same-cycle expiry.
      ACTIVE: begin
        if (bus.collected) begin
          active_n = 1'b0;
          state_n  = COOLDOWN;
        end
`ifdef PICKUP_LIFETIME_EN
        else if (cnt_tc) begin
          active_n = 1'b0;
          expire_n = 1'b1;
          state_n  = COOLDOWN;
        end
`endif
      end

      default: state_n = IDLE;
    endcase

    // Every failed draw or blocked answer burns a try; the last one
    // abandons this attempt and waits a full delay.
    if (try_fail) begin
      if (tries_q == TRY_LAST) begin
        tries_n = '0;
        state_n = COOLDOWN;
      end else begin
        tries_n = tries_q + 1'b1;
        state_n = DRAW_X;
      end
    end

    if (!bus.game_active) begin
      state_n      = IDLE;
      tries_n      = '0;
      cand_x_n     = '0;
      cand_y_n     = '0;
      cand_type_n  = HEALTH;
      cand_valid_n = 1'b0;
      active_n     = 1'b0;
      px_n         = '0;
      py_n         = '0;
      ptype_n      = HEALTH;
      spawn_n      = 1'b0;
      expire_n     = 1'b0;
    end

    cnt_clr = (state_n != state);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      tries_q      <= '0;
      cand_x_q     <= '0;
      cand_y_q     <= '0;
      cand_type_q  <= HEALTH;
      cand_valid_q <= 1'b0;
      active_q     <= 1'b0;
      px_q         <= '0;
      py_q         <= '0;
      ptype_q      <= HEALTH;
      spawn_q      <= 1'b0;
      expire_q     <= 1'b0;
    end else begin
      tries_q      <= tries_n;
      cand_x_q     <= cand_x_n;
      cand_y_q     <= cand_y_n;
      cand_type_q  <= cand_type_n;
      cand_valid_q <= cand_valid_n;
      active_q     <= active_n;
      px_q         <= px_n;
      py_q         <= py_n;
      ptype_q      <= ptype_n;
      spawn_q      <= spawn_n;
      expire_q     <= expire_n;
    end
  end

  assign bus.cand_valid    = cand_valid_q;
  assign bus.cand_x        = cand_x_q;
  assign bus.cand_y        = cand_y_q;
  assign bus.pickup_active = active_q;
  assign bus.pickup_x      = px_q;
  assign bus.pickup_y      = py_q;
  assign bus.pickup_type   = ptype_q;
  assign bus.spawn_pulse   = spawn_q;
  assign bus.expire_pulse  = expire_q;
endmodule

// File: tb/tb_pickup_spawner.sv
// Directed bench for pickup_spawner (SPAWN_DELAY=3, LIFETIME=2,
// MAX_TRIES=8). Expiry checks adapt to PICKUP_LIFETIME_EN.
module tb_pickup_spawner;
  import pickup_spawner_pkg::*;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  pickup_spawner_if bus();

  pickup_spawner #(
    .SPAWN_DELAY(3),
    .LIFETIME   (2),
    .MAX_TRIES  (8)
  ) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {18'd0, bus.cand_valid, bus.cand_x, bus.cand_y, bus.pickup_active,
            bus.pickup_x, bus.pickup_y, 2'(bus.pickup_type), bus.spawn_pulse,
            bus.expire_pulse};
  endfunction

  task automatic tick();
    bus.frame_tick = 1'b1;
    @(negedge Clk);
    bus.frame_tick = 1'b0;
    @(negedge Clk);
  endtask

  // Three ticks; returns right after the final tick edge (state DRAW_X).
  task automatic cooldown();
    for (int i = 0; i < 3; i++) begin
      bus.frame_tick = 1'b1;
      @(negedge Clk);
      bus.frame_tick = 1'b0;
      if (i < 2) @(negedge Clk);
    end
  endtask

  // One rand_in value per draw cycle; only the last draw raises cand_valid.
  task automatic draw(input string tag, input int v[5], input int n);
    for (int i = 0; i < n; i++) begin
      bus.rand_in = 10'(v[i]);
      @(negedge Clk);
      chk($sformatf("%s_cv%0d", tag, i), 64'(bus.cand_valid), 64'(i == n - 1));
    end
  endtask

  task automatic expect_spawn(input string tag, input int x, input int y, input int t);
    chk({tag, "_cand_x"}, 64'(bus.cand_x), 64'(x));
    chk({tag, "_cand_y"}, 64'(bus.cand_y), 64'(y));
    @(negedge Clk);
    chk({tag, "_spawn"}, 64'(bus.spawn_pulse), 64'd1);
    chk({tag, "_active"}, 64'(bus.pickup_active), 64'd1);
    chk({tag, "_px"}, 64'(bus.pickup_x), 64'(x));
    chk({tag, "_py"}, 64'(bus.pickup_y), 64'(y));
    chk({tag, "_type"}, 64'(bus.pickup_type), 64'(t));
    @(negedge Clk);
    chk({tag, "_spawn_off"}, 64'(bus.spawn_pulse), 64'd0);
  endtask

  task automatic collect(input string tag);
    bus.collected = 1'b1;
    @(negedge Clk);
    bus.collected = 1'b0;
    chk({tag, "_active"}, 64'(bus.pickup_active), 64'd0);
    chk({tag, "_expire"}, 64'(bus.expire_pulse), 64'd0);
    chk({tag, "_state"}, 64'(dut.state), 64'(COOLDOWN));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [63:0] acc;
    int cv, sp;
    bus.frame_tick = 1'b0;
    bus.game_active = 1'b0;
    bus.rand_in = '0;
    bus.collected = 1'b0;
    bus.blocked = 1'b0;

    // Reset and idle
    repeat (3) @(negedge Clk);
    chk("rst_outs", outs(), 64'd0);
    chk("rst_state", 64'(dut.state), 64'(IDLE));
    Reset_n = 1'b1;
    acc = '0;
    for (int i = 0; i < 1000; i++) begin
      bus.frame_tick = (i % 7 == 0);
      @(negedge Clk);
      acc |= outs();
    end
    bus.frame_tick = 1'b0;
    chk("idle_outs", acc, 64'd0);
    chk("idle_state", 64'(dut.state), 64'(IDLE));

    // Clean spawn
    bus.game_active = 1'b1;
    @(negedge Clk);
    chk("cool_state", 64'(dut.state), 64'(COOLDOWN));
    cooldown();
    chk("drawx_state", 64'(dut.state), 64'(DRAW_X));
    draw("clean", '{100, 200, 0, 0, 0}, 2);
    expect_spawn("clean", 100, 200, 0);

    // Collect on the expiry tick: collection wins
    tick();
    chk("cx_alive", 64'(bus.pickup_active), 64'd1);
    bus.frame_tick = 1'b1;
    bus.collected = 1'b1;
    @(negedge Clk);
    bus.frame_tick = 1'b0;
    bus.collected = 1'b0;
    chk("cx_active", 64'(bus.pickup_active), 64'd0);
    chk("cx_expire", 64'(bus.expire_pulse), 64'd0);
    @(negedge Clk);
    chk("cx_expire2", 64'(bus.expire_pulse), 64'd0);

    // Expiry without collected
    cooldown();
    draw("exp", '{100, 200, 0, 0, 0}, 2);
    expect_spawn("exp", 100, 200, 0);
    tick();
    bus.frame_tick = 1'b1;
    @(negedge Clk);
    bus.frame_tick = 1'b0;
`ifdef PICKUP_LIFETIME_EN
    chk("exp_pulse", 64'(bus.expire_pulse), 64'd1);
    chk("exp_active", 64'(bus.pickup_active), 64'd0);
`else
    chk("exp_pulse", 64'(bus.expire_pulse), 64'd0);
    chk("exp_active", 64'(bus.pickup_active), 64'd1);
`endif
    @(negedge Clk);
    chk("exp_once", 64'(bus.expire_pulse), 64'd0);
    collect("exp_col");

    // Range rejection
    cooldown();
    draw("rng", '{700, 50, 470, 50, 60}, 5);
    expect_spawn("rng", 50, 60, 0);
    collect("rng_col");

    // Blocked exhaustion
    bus.blocked = 1'b1;
    bus.rand_in = 10'd10;
    cooldown();
    cv = 0;
    sp = 0;
    repeat (40) begin
      @(negedge Clk);
      cv += int'(bus.cand_valid);
      sp += int'(bus.spawn_pulse);
    end
    chk("blk_cand_pulses", 64'(cv), 64'd8);
    chk("blk_spawns", 64'(sp), 64'd0);
    chk("blk_state", 64'(dut.state), 64'(COOLDOWN));
    chk("blk_active", 64'(bus.pickup_active), 64'd0);
    bus.blocked = 1'b0;
    cooldown();
    draw("retry", '{10, 10, 0, 0, 0}, 2);
    expect_spawn("retry", 10, 10, 0);
    collect("retry_col");

    // Range boundaries and type from rand_in[9:8]
    cooldown();
    draw("bnd", '{624, 623, 464, 623, 773}, 5);
    expect_spawn("bnd", 623, 261, 3);

    // game_active drop while ACTIVE
    bus.game_active = 1'b0;
    @(negedge Clk);
    chk("drop_state", 64'(dut.state), 64'(IDLE));
    chk("drop_active", 64'(bus.pickup_active), 64'd0);
    chk("drop_expire", 64'(bus.expire_pulse), 64'd0);
    chk("drop_outs", outs(), 64'd0);

    // Asynchronous reset mid-operation
    bus.game_active = 1'b1;
    @(negedge Clk);
    cooldown();
    draw("ar", '{300, 612, 0, 0, 0}, 2);
    expect_spawn("ar", 300, 100, 2);
    #2 Reset_n = 1'b0;
    #1;
    chk("arst_outs", outs(), 64'd0);
    chk("arst_state", 64'(dut.state), 64'(IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
